// File: rtl/temporal_encoder.sv
// temporal_encoder: converts a spike-time word into a registered pulse on q,
// positioned inside a gamma window of GAMMA_CYCLE_WIDTH cycles opened by set.
// A one-deep pending buffer accepts the next word at any time; it is consumed
// at the next set, or bypassed straight into the active slot if set and an
// accepted word coincide while the buffer is empty.
// Build option: define TENC_STEP_EN for step encoding (q stays high from
// cycle value+1 to the window end; PULSE_WIDTH is then unused).
module temporal_encoder #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8
) (
    input  logic                                 aclk,
    input  logic                                 grst_n,
    input  logic                                 set,
    input  logic                                 in_valid,
    input  logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] in_value,
    input  logic                                 in_inf,
    output logic                                 in_ready,
    output logic                                 q,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned VW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int unsigned CW = VW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PULSE,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   gcnt_q, gcnt_d;
    logic [VW-1:0]   pend_value_q, pend_value_d;
    logic            pend_inf_q, pend_inf_d;
    logic            pend_valid_q, pend_valid_d;
    logic [VW-1:0]   act_value_q, act_value_d;
    logic            act_inf_q, act_inf_d;
    logic            q_q, q_d;
    logic            done_q, done_d;

    logic            accept;
    logic [31:0]     ncyc;

    assign in_ready = ~pend_valid_q;
    assign accept   = in_valid && !pend_valid_q;
    assign busy     = (state_q != IDLE);
    assign q        = q_q;
    assign done     = done_q;

    // Buffers, window counter and next-state/output decode. The decode works on
    // the cycle number about to start (ncyc, 0 = idle) and the active word that
    // will be in force then, so q and done come straight out of flops.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_inf_d   = pend_inf_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_inf_d    = act_inf_q;
        state_d      = state_q;
        gcnt_d       = gcnt_q;
        ncyc         = 32'd0;

        if (set && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end else if (accept && !set) begin
            pend_value_d = in_value;
            pend_inf_d   = in_inf;
            pend_valid_d = 1'b1;
        end

        if (set) begin
            if (pend_valid_q) begin
                act_value_d = pend_value_q;
                act_inf_d   = pend_inf_q;
            end else if (accept) begin
                act_value_d = in_value;
                act_inf_d   = in_inf;
            end else begin
                act_value_d = '0;
                act_inf_d   = 1'b1;
            end
        end

        if (set) begin
            ncyc   = 32'd1;
            gcnt_d = CW'(1);
        end else if (state_q != IDLE && 32'(gcnt_q) < GAMMA_CYCLE_WIDTH) begin
            ncyc   = 32'(gcnt_q) + 32'd1;
            gcnt_d = gcnt_q + 1'b1;
        end

        if (ncyc == 32'd0) begin
            state_d = IDLE;
        end else if (act_inf_d) begin
            state_d = WAIT;
        end else if (ncyc <= 32'(act_value_d)) begin
            state_d = WAIT;
        end else begin
`ifdef TENC_STEP_EN
            state_d = PULSE;
`else
            if (ncyc <= 32'(act_value_d) + PULSE_WIDTH) begin
                state_d = PULSE;
            end else begin
                state_d = HOLD;
            end
`endif
        end

        q_d    = (state_d == PULSE);
        done_d = (ncyc == GAMMA_CYCLE_WIDTH);
    end

    // State, counter, buffers and registered outputs; reset clears everything
    // and leaves the active slot holding "no spike".
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q      <= IDLE;
            gcnt_q       <= '0;
            pend_value_q <= '0;
            pend_inf_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_inf_q    <= 1'b1;
            q_q          <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gcnt_q       <= gcnt_d;
            pend_value_q <= pend_value_d;
            pend_inf_q   <= pend_inf_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_inf_q    <= act_inf_d;
            q_q          <= q_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 The module SHALL have parameter GAMMA_CYCLE_WIDTH, default 16, giving the gamma cycle length in aclk cycles.
REQ-002 The module SHALL have parameter PULSE_WIDTH, default 8, giving the spike pulse length in aclk cycles.
REQ-003 The module SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port grst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port set, input, 1 bit: gamma-cycle start strobe, one cycle wide.
REQ-006 The module SHALL have port in_valid, input, 1 bit: spike-time word offered.
REQ-007 The module SHALL have port in_value, input, $clog2(GAMMA_CYCLE_WIDTH) bits: spike time in cycles.
REQ-008 The module SHALL have port in_inf, input, 1 bit: with in_valid, "no spike this gamma cycle" (in_value ignored).
REQ-009 The module SHALL have port in_ready, output, 1 bit: pending buffer empty, word accepted when in_valid && in_ready.
REQ-010 The module SHALL have port q, output, 1 bit: registered temporally encoded spike.
REQ-011 The module SHALL have port busy, output, 1 bit: gamma window active.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle strobe at the last cycle of the gamma window.

Function
REQ-013 The module SHALL hold a pending register (value, inf, valid) and an active register (value, inf); in_ready SHALL equal ~pending_valid.
REQ-014 The module SHALL use a gamma counter gcnt, width $clog2(GAMMA_CYCLE_WIDTH)+1, cleared to 1 at the edge sampling set=1 and incremented each cycle while busy.
REQ-015 At the set edge, if pending_valid, the active register SHALL load pending and pending_valid SHALL clear; otherwise the active register SHALL load inf=1.
REQ-016 If set and an accepted word coincide while pending is empty, the word SHALL bypass into the active register for this gamma cycle and pending SHALL stay empty.
REQ-017 The FSM SHALL have states IDLE (busy=0), WAIT (gcnt<=active value), PULSE (q high), and HOLD (spike finished, window still open); set SHALL move any state to WAIT, or directly to PULSE when the active value is 0.
REQ-018 q SHALL be high on cycles value+1 through min(value+PULSE_WIDTH, GAMMA_CYCLE_WIDTH) after the set edge, counted from 1.
REQ-019 A pulse running past GAMMA_CYCLE_WIDTH SHALL be truncated at the window end.
REQ-020 If the active inf is 1, q SHALL stay low for the whole window.
REQ-021 busy SHALL be high on cycles 1..GAMMA_CYCLE_WIDTH after set; done SHALL pulse on cycle GAMMA_CYCLE_WIDTH; the FSM SHALL then return to IDLE.
REQ-022 A set arriving while busy SHALL restart the window: gcnt SHALL return to 1, any pulse SHALL be abandoned, the new active value SHALL apply, and done SHALL NOT pulse for the aborted window.
REQ-023 The pending register SHALL be writable in any state, including mid-window; a written value SHALL apply to the next set only.

Reset
REQ-024 grst_n low SHALL immediately force q=0, busy=0, done=0, in_ready=1, FSM=IDLE, gcnt=0, pending_valid=0, and active inf=1.
REQ-025 Reset asserted mid-pulse SHALL drop q asynchronously, and no stale value SHALL survive deassertion.

Configuration
REQ-026 With macro TENC_STEP_EN defined, q SHALL be step-encoded: it rises at cycle value+1 and stays high through cycle GAMMA_CYCLE_WIDTH, and PULSE_WIDTH is unused.
REQ-027 Without TENC_STEP_EN, q SHALL be pulse-encoded per REQ-018.

Verification (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8)
REQ-028 Load value 3, then set -> q high on cycles 4..11, done on cycle 16, busy on cycles 1..16.
REQ-029 Load value 12, then set -> q high on cycles 13..16 only (truncated, 4 cycles).
REQ-030 Load in_inf=1, then set -> q low for all 16 cycles, done on cycle 16.
REQ-031 Set and in_valid (value 0) in the same cycle with pending empty -> q high on cycles 1..8, in_ready stays 1.
REQ-032 Load value 2, set, load value 5 at cycle 3, second set at cycle 6 -> q high on cycles 3..6 of the first window only, then q high on cycles 6..13 of the new window, no done for the first window.
REQ-033 Reset at cycle 7 of a value-3 pulse -> q=0 at once, in_ready=1, and a later set with no load gives q low.
